// File: rtl/mapper_ctx_seq.sv
// Hypervisor mapper context sequencer.
//
// On trap entry, copies the four user-map register bytes (A/X/Y/Z) out of the mapper
// into a shadow buffer and switches the mapper to the hypervisor map set. While the
// hypervisor runs, the shadow bytes are reachable through a small I/O port. On exit,
// only the bytes the hypervisor modified are written back, then the user map returns.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   hyp_enter, hyp_exit   single-cycle trap entry / exit requests
//   map_idle, map_start   mapper MAP FSM status, used to find a safe point to stall
//   rd_sel / rd_data      combinational read of a mapper user register byte
//   wr_en/wr_sel/wr_data  mapper user register load path
//   io_we/io_addr/io_wdata/io_rdata  hypervisor shadow access (0=A 1=X 2=Y 3=Z)
//   stall                 forces CPU ready low during save/restore
//   active_map            0 = user map set, 1 = hypervisor map set
//   in_hyp                hypervisor context active
module mapper_ctx_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hyp_enter,
  input  logic       hyp_exit,
  input  logic       map_idle,
  input  logic       map_start,
  input  logic [7:0] rd_data,
  input  logic       io_we,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic       stall,
  output logic       active_map,
  output logic       in_hyp,
  output logic [1:0] rd_sel,
  output logic       wr_en,
  output logic [1:0] wr_sel,
  output logic [7:0] wr_data,
  output logic [7:0] io_rdata
);

  typedef enum logic [2:0] {
    StUser,
    StSavePend,
    StSave,
    StHyp,
    StRestorePend,
    StRestore
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];
  logic [3:0] dirty_q, dirty_d;
  logic       safe;

  // The mapper loads its registers while the CPU is not ready, so raising stall in
  // the middle of a MAP (or on the cycle one is accepted) would deadlock it.
  assign safe = map_idle & ~map_start;

  assign io_rdata = shadow_q[io_addr];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    dirty_d    = dirty_q;
    stall      = 1'b0;
    active_map = 1'b0;
    in_hyp     = 1'b0;
    rd_sel     = 2'd0;
    wr_en      = 1'b0;
    wr_sel     = 2'd0;
    wr_data    = 8'd0;

    case (state_q)
      StUser: begin
        // hyp_exit is meaningless here; enter wins when both arrive together.
        if (hyp_enter) begin
          state_d = safe ? StSave : StSavePend;
        end
      end

      StSavePend: begin
        if (safe) begin
          state_d = StSave;
        end
      end

      StSave: begin
        stall                = 1'b1;
        rd_sel               = idx_q;
        shadow_d[idx_q]      = rd_data;
        dirty_d[idx_q]       = 1'b0;
        idx_d                = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StHyp;
        end
      end

      StHyp: begin
        active_map = 1'b1;
        in_hyp     = 1'b1;
        // A write in the exit cycle still lands and is marked for restore.
        if (io_we) begin
          shadow_d[io_addr] = io_wdata;
          dirty_d[io_addr]  = 1'b1;
        end
        if (hyp_exit) begin
          state_d = safe ? StRestore : StRestorePend;
        end
      end

      StRestorePend: begin
        active_map = 1'b1;
        if (safe) begin
          state_d = StRestore;
        end
      end

      StRestore: begin
        stall          = 1'b1;
        active_map     = 1'b1;
        wr_sel         = idx_q;
        wr_data        = shadow_q[idx_q];
        wr_en          = dirty_q[idx_q];
        dirty_d[idx_q] = 1'b0;
        idx_d          = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StUser;
        end
      end

      default: begin
        state_d = StUser;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StUser;
      idx_q    <= 2'd0;
      shadow_q <= '{default: 8'd0};
      dirty_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

endmodule

// File: tb/tb_mapper_ctx_seq.sv
module tb_mapper_ctx_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hyp_enter, hyp_exit, map_idle, map_start;
  logic [7:0] rd_data;
  logic       io_we;
  logic [1:0] io_addr;
  logic [7:0] io_wdata;
  logic       stall, active_map, in_hyp;
  logic [1:0] rd_sel;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [7:0] io_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mapper_ctx_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hyp_enter  (hyp_enter),
    .hyp_exit   (hyp_exit),
    .map_idle   (map_idle),
    .map_start  (map_start),
    .rd_data    (rd_data),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .stall      (stall),
    .active_map (active_map),
    .in_hyp     (in_hyp),
    .rd_sel     (rd_sel),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .io_rdata   (io_rdata)
  );

  // Mapper user registers: combinational read, load on wr_en at the closing edge.
  logic [7:0] mregs [4];
  assign rd_data = mregs[rd_sel];
  always @(posedge clk) begin
    if (wr_en) mregs[wr_sel] <= wr_data;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard of expected mapper writes {sel, data}, pushed when the hypervisor write
  // is driven, popped when the DUT strobes wr_en.
  logic [9:0] sb_q [$];
  always @(negedge clk) begin
    if (wr_en) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", {22'd0, wr_sel, wr_data}, 32'hdead);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        check("sb_write", {22'd0, wr_sel, wr_data}, {22'd0, e});
      end
    end
  end

  typedef struct {
    logic       en, ex, idle, start, we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       sb;
    logic       e_stall, e_act, e_hyp;
    logic [1:0] e_rdsel;
    logic       e_wren;
    logic       chk;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t v(input logic en, input logic ex, input logic idle,
                             input logic start, input logic we, input logic [1:0] addr,
                             input logic [7:0] wdata, input logic sb, input logic st,
                             input logic act, input logic hyp, input logic [1:0] rds,
                             input logic wren, input logic chk, input logic [7:0] rdata);
    vec_t r;
    r.en = en; r.ex = ex; r.idle = idle; r.start = start; r.we = we;
    r.addr = addr; r.wdata = wdata; r.sb = sb;
    r.e_stall = st; r.e_act = act; r.e_hyp = hyp; r.e_rdsel = rds; r.e_wren = wren;
    r.chk = chk; r.e_rdata = rdata;
    return r;
  endfunction

  initial begin
    mregs[0] = 8'h12; mregs[1] = 8'h34; mregs[2] = 8'h56; mregs[3] = 8'h78;
    reset_n = 1'b0; hyp_enter = 1'b0; hyp_exit = 1'b0; map_idle = 1'b1; map_start = 1'b0;
    io_we = 1'b0; io_addr = 2'd0; io_wdata = 8'd0;

    //            en ex id st we ad wdata sb  st ac hy rs we chk rdata
    // Entry save with A..Z = 12/34/56/78
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 2'(i), 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h12));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h34));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h56));
    vecs.push_back(v(0, 0, 1, 0, 0, 3, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h78));
    // Dirty-only restore: write Y=A5, exit
    vecs.push_back(v(0, 0, 1, 0, 1, 2, 8'hA5, 1, 0, 1, 1, 0, 0, 1, 8'h56));
    vecs.push_back(v(0, 1, 1, 0, 0, 2, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    // io_we in USER is ignored
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 8'h12));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h12));
    // enter+exit in USER, mapper busy for 3 cycles afterwards
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 2'(i), 0, 0, 8'h00));
    // HYP: enter+exit+write A=3C with map_start -> restore pending, A written back
    vecs.push_back(v(1, 1, 1, 1, 1, 0, 8'h3C, 1, 0, 1, 1, 0, 0, 1, 8'h12));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 0, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    // Entry with map_start high goes through SAVE_PEND
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 2'(i), 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h3C));
    // All clean: 4 stalled restore cycles, no writes
    vecs.push_back(v(0, 1, 1, 0, 0, 2, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'hA5));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    // Reset state
    #12;
    check("rst_outputs", {26'd0, stall, active_map, in_hyp, rd_sel, wr_en},  32'd0);
    check("rst_wr_path", {22'd0, wr_sel, wr_data}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      io_addr = 2'(a);
      #1 check("rst_io_rdata", {24'd0, io_rdata}, 32'd0);
    end
    io_addr = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      hyp_enter = vecs[i].en;  hyp_exit = vecs[i].ex;
      map_idle  = vecs[i].idle; map_start = vecs[i].start;
      io_we = vecs[i].we; io_addr = vecs[i].addr; io_wdata = vecs[i].wdata;
      if (vecs[i].sb) sb_q.push_back({vecs[i].addr, vecs[i].wdata});
      @(negedge clk);
      check($sformatf("row%0d_outputs", i),
            {26'd0, stall, active_map, in_hyp, rd_sel, wr_en},
            {26'd0, vecs[i].e_stall, vecs[i].e_act, vecs[i].e_hyp, vecs[i].e_rdsel,
             vecs[i].e_wren});
      if (vecs[i].chk)
        check($sformatf("row%0d_io_rdata", i), {24'd0, io_rdata}, {24'd0, vecs[i].e_rdata});
    end
    check("mapper_regs", {mregs[0], mregs[1], mregs[2], mregs[3]}, 32'h3C34A578);

    // Reset asserted during the 2nd SAVE cycle
    @(posedge clk); #1;
    hyp_enter = 1'b1; hyp_exit = 1'b0; map_idle = 1'b1; map_start = 1'b0; io_we = 1'b0;
    @(posedge clk); #1;
    hyp_enter = 1'b0;
    @(posedge clk); #1;
    check("midsave_pre", {30'd0, stall, rd_sel == 2'd1}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("midsave_async", {29'd0, stall, active_map, in_hyp}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      io_addr = 2'(a);
      #1 check("midsave_shadow", {24'd0, io_rdata}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_user", {26'd0, stall, active_map, in_hyp, rd_sel, wr_en}, 32'd0);
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
